// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for the stall/flush statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    input  logic         clear_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, ID branch flushes and
// multi-cycle data-memory freezes, with a memory-timeout trap and perf counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal flow; hazards resolved combinationally each cycle
// MEM_WAIT | data-memory access outstanding, back end frozen until ack
// ERROR    | memory timed out; pipeline frozen until reset
module hazard_stall_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  start_i,
    input  logic [REG_ADDR_W-1:0] RS1addr_i,
    input  logic [REG_ADDR_W-1:0] RS2addr_i,
    input  logic                  RS1used_i,
    input  logic                  RS2used_i,
    input  logic                  MemRead_ex_i,
    input  logic [REG_ADDR_W-1:0] RDaddr_ex_i,
    input  logic                  BranchTaken_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic                  PCWrite_o,
    output logic                  IFIDWrite_o,
    output logic                  IFIDFlush_o,
    output logic                  IDEXBubble_o,
    output logic                  PipeFreeze_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_stall;
    logic              load_use;

    assign load_use = MemRead_ex_i && (RDaddr_ex_i != REG_X0) &&
                      ((RS1used_i && (RS1addr_i == RDaddr_ex_i)) ||
                       (RS2used_i && (RS2addr_i == RDaddr_ex_i)));

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        mem_stall    = 1'b0;
        PCWrite_o    = 1'b1;
        IFIDWrite_o  = 1'b1;
        IFIDFlush_o  = 1'b0;
        IDEXBubble_o = 1'b0;
        PipeFreeze_o = 1'b0;

        case (state_q)
            RUN: begin
                wait_d = '0;
                if (mem_req_i && !mem_ack_i) begin
                    mem_stall = 1'b1;
                    state_d   = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                if (mem_ack_i) begin
                    state_d = RUN;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = ERROR;
                    end
                end
            end
            ERROR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Memory stall outranks load-use, which in turn swallows a same-cycle branch.
        if (mem_stall) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            PipeFreeze_o = 1'b1;
        end else if (load_use) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXBubble_o = 1'b1;
        end else if (BranchTaken_i) begin
            IFIDFlush_o  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign err_o = (state_q == ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (start_i),
        .inc_i   (!PCWrite_o),
        .clear_i (1'b0),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (start_i),
        .inc_i   (IFIDFlush_o),
        .clear_i (1'b0),
        .cnt_o   (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = 15;

    logic             clk_i = 1'b0;
    logic             start_i;
    logic [4:0]       RS1addr_i, RS2addr_i, RDaddr_ex_i;
    logic             RS1used_i, RS2used_i, MemRead_ex_i, BranchTaken_i;
    logic             mem_req_i, mem_ack_i;
    logic             PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeFreeze_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // model: mode 0=running, 1=waiting on memory, 2=trapped
    int m_mode, m_waited, m_stalls, m_flushes;

    hazard_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .start_i(start_i),
        .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i),
        .RS1used_i(RS1used_i), .RS2used_i(RS2used_i),
        .MemRead_ex_i(MemRead_ex_i), .RDaddr_ex_i(RDaddr_ex_i),
        .BranchTaken_i(BranchTaken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .IFIDFlush_o(IFIDFlush_o),
        .IDEXBubble_o(IDEXBubble_o), .PipeFreeze_o(PipeFreeze_o), .err_o(err_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic clear_inputs();
        RS1addr_i = '0; RS2addr_i = '0; RDaddr_ex_i = '0;
        RS1used_i = 0; RS2used_i = 0; MemRead_ex_i = 0; BranchTaken_i = 0;
        mem_req_i = 0; mem_ack_i = 0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        MemRead_ex_i = 1; RDaddr_ex_i = rd; RS2used_i = 1; RS2addr_i = rd;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_tests++;
        if ({PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeFreeze_o, err_o} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 110000",
                     {PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeFreeze_o, err_o});
        end
        n_tests++;
        if (stall_cnt_o !== 0 || flush_cnt_o !== 0) begin
            n_fail++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0/0", stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load_use(5'd5);
        #1;
        n_tests++;
        if ({PCWrite_o, IFIDWrite_o, IDEXBubble_o, IFIDFlush_o, PipeFreeze_o} !== 5'b00100) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b expected 00100",
                     {PCWrite_o, IFIDWrite_o, IDEXBubble_o, IFIDFlush_o, PipeFreeze_o});
        end
        step();
        clear_inputs();
        #1;
        n_tests++;
        if (stall_cnt_o !== 1 || PCWrite_o !== 1) begin
            n_fail++;
            $display("FAIL load_use_count: got stall=%0d pc=%b expected 1/1", stall_cnt_o, PCWrite_o);
        end
        set_load_use(5'd0);
        #1;
        n_tests++;
        if (PCWrite_o !== 1 || IDEXBubble_o !== 0) begin
            n_fail++;
            $display("FAIL load_use_x0: got pc=%b bubble=%b expected 1/0", PCWrite_o, IDEXBubble_o);
        end
        step();
        clear_inputs();
        #1;
        n_tests++;
        if (stall_cnt_o !== 1) begin
            n_fail++;
            $display("FAIL load_use_x0_count: got %0d expected 1", stall_cnt_o);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        BranchTaken_i = 1;
        #1;
        n_tests++;
        if ({IFIDFlush_o, PCWrite_o, IFIDWrite_o, IDEXBubble_o} !== 4'b1110) begin
            n_fail++;
            $display("FAIL branch_flush: got %b expected 1110",
                     {IFIDFlush_o, PCWrite_o, IFIDWrite_o, IDEXBubble_o});
        end
        step();
        set_load_use(5'd7);
        #1;
        n_tests++;
        if (flush_cnt_o !== 1) begin
            n_fail++;
            $display("FAIL branch_count: got %0d expected 1", flush_cnt_o);
        end
        n_tests++;
        if ({IFIDFlush_o, IDEXBubble_o, PCWrite_o} !== 3'b010) begin
            n_fail++;
            $display("FAIL branch_vs_load_use: got %b expected 010", {IFIDFlush_o, IDEXBubble_o, PCWrite_o});
        end
        step();
        clear_inputs();
        #1;
        n_tests++;
        if (flush_cnt_o !== 1 || stall_cnt_o !== 1) begin
            n_fail++;
            $display("FAIL branch_suppressed_count: got flush=%0d stall=%0d expected 1/1", flush_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            clear_inputs();
            mem_req_i = 1;
            mem_ack_i = (k == 3);
            if (k == 1) begin
                set_load_use(5'd9);
                BranchTaken_i = 1;
            end
            #1;
            n_tests++;
            if (PipeFreeze_o !== (k < 3) || PCWrite_o !== (k == 3)) begin
                n_fail++;
                $display("FAIL mem_wait_freeze[%0d]: got freeze=%b pc=%b expected %b/%b",
                         k, PipeFreeze_o, PCWrite_o, k < 3, k == 3);
            end
            if (k == 1) begin
                n_tests++;
                if (IDEXBubble_o !== 0 || IFIDFlush_o !== 0) begin
                    n_fail++;
                    $display("FAIL mem_wait_ignore: got bubble=%b flush=%b expected 0/0", IDEXBubble_o, IFIDFlush_o);
                end
            end
            step();
        end
        clear_inputs();
        mem_req_i = 1;
        mem_ack_i = 1;
        #1;
        n_tests++;
        if (PipeFreeze_o !== 0 || PCWrite_o !== 1 || stall_cnt_o !== 3) begin
            n_fail++;
            $display("FAIL mem_wait_done: got freeze=%b pc=%b stall=%0d expected 0/1/3",
                     PipeFreeze_o, PCWrite_o, stall_cnt_o);
        end
        step();
        clear_inputs();
        #1;
        n_tests++;
        if (stall_cnt_o !== 3) begin
            n_fail++;
            $display("FAIL mem_single_cycle: got stall=%0d expected 3", stall_cnt_o);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_req_i = 1;
        step();
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            #1;
            n_tests++;
            if (err_o !== 0 || PipeFreeze_o !== 1) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: got err=%b freeze=%b expected 0/1", k, err_o, PipeFreeze_o);
            end
            step();
        end
        clear_inputs();
        mem_ack_i = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (err_o !== 1 || PCWrite_o !== 0 || PipeFreeze_o !== 1) begin
                n_fail++;
                $display("FAIL timeout_trap[%0d]: got err=%b pc=%b freeze=%b expected 1/0/1",
                         k, err_o, PCWrite_o, PipeFreeze_o);
            end
            step();
        end
        apply_reset();
        #1;
        n_tests++;
        if (err_o !== 0 || PCWrite_o !== 1 || stall_cnt_o !== 0) begin
            n_fail++;
            $display("FAIL timeout_reset: got err=%b pc=%b stall=%0d expected 0/1/0", err_o, PCWrite_o, stall_cnt_o);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            set_load_use(5'd3);
            step();
            #1;
            if (k == 14 || k == 20) begin
                n_tests++;
                if (stall_cnt_o !== ((k < CNT_MAX) ? k : CNT_MAX)) begin
                    n_fail++;
                    $display("FAIL saturation[%0d]: got %0d expected %0d",
                             k, stall_cnt_o, (k < CNT_MAX) ? k : CNT_MAX);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        mem_req_i = 1;
        step();
        mem_req_i = 0;
        step();
        #1;
        n_tests++;
        if (PipeFreeze_o !== 1 || stall_cnt_o !== 2) begin
            n_fail++;
            $display("FAIL mid_wait_pre: got freeze=%b stall=%0d expected 1/2", PipeFreeze_o, stall_cnt_o);
        end
        start_i = 0;
        #1;
        n_tests++;
        if ({PCWrite_o, IFIDWrite_o, PipeFreeze_o, err_o} !== 4'b1100 || stall_cnt_o !== 0) begin
            n_fail++;
            $display("FAIL mid_wait_async_reset: got %b stall=%0d expected 1100 stall=0",
                     {PCWrite_o, IFIDWrite_o, PipeFreeze_o, err_o}, stall_cnt_o);
        end
        @(negedge clk_i);
        start_i = 1;
        step();
    endtask

    task automatic test_random();
        logic       lu, ms, exp_pc, exp_bub, exp_fl, exp_fr;
        logic [7:0] got, exp;
        int         trapped_for;
        apply_reset();
        m_mode = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
        trapped_for = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (m_mode == 2 && trapped_for > 3) begin
                apply_reset();
                m_mode = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
                trapped_for = 0;
            end
            RS1addr_i     = 5'($urandom_range(0, 3));
            RS2addr_i     = 5'($urandom_range(0, 3));
            RDaddr_ex_i   = 5'($urandom_range(0, 3));
            RS1used_i     = 1'($urandom_range(0, 1));
            RS2used_i     = 1'($urandom_range(0, 1));
            MemRead_ex_i  = 1'($urandom_range(0, 1));
            BranchTaken_i = 1'($urandom_range(0, 1));
            mem_req_i     = ($urandom_range(0, 3) == 0);
            mem_ack_i     = ($urandom_range(0, 3) == 0);
            #1;
            lu = MemRead_ex_i && RDaddr_ex_i != 0 &&
                 ((RS1used_i && RS1addr_i == RDaddr_ex_i) || (RS2used_i && RS2addr_i == RDaddr_ex_i));
            if (m_mode == 2)      ms = 1;
            else if (m_mode == 1) ms = !mem_ack_i;
            else                  ms = mem_req_i && !mem_ack_i;
            exp_pc  = !(ms || lu);
            exp_fr  = ms;
            exp_bub = !ms && lu;
            exp_fl  = !ms && !lu && BranchTaken_i;
            exp = {exp_pc, exp_pc, exp_fl, exp_bub, exp_fr, 1'(m_mode == 2), 2'b00};
            got = {PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeFreeze_o, err_o, 2'b00};
            n_tests++;
            if (got !== exp || stall_cnt_o !== m_stalls || flush_cnt_o !== m_flushes) begin
                n_fail++;
                $display("FAIL random[%0d]: got ctl=%b stall=%0d flush=%0d expected ctl=%b stall=%0d flush=%0d",
                         cyc, got, stall_cnt_o, flush_cnt_o, exp, m_stalls, m_flushes);
            end
            if (!exp_pc && m_stalls < CNT_MAX) m_stalls++;
            if (exp_fl && m_flushes < CNT_MAX) m_flushes++;
            if (m_mode == 0 && mem_req_i && !mem_ack_i) begin
                m_mode = 1; m_waited = 0;
            end else if (m_mode == 1) begin
                if (mem_ack_i) m_mode = 0;
                else begin
                    m_waited++;
                    if (m_waited == MEM_TIMEOUT) m_mode = 2;
                end
            end else if (m_mode == 2) begin
                trapped_for++;
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        start_i = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
